regfile_param_scoreboard: RTL and testbench

- Parametrised successor to the CPU's fixed 32x32 two-read/one-write register file.
- Depth and width are configurable; register 0 can optionally be hardwired to zero.
- Adds an asynchronous clear, an optional write-to-read bypass, and a per-register pending-write scoreboard for hazard detection in the pipelined datapath.
- Sits between decode (read/issue) and writeback (write) stages.

---
 rtl/regfile_param_scoreboard.sv | 112 +++++++++++
 tb/tb_regfile_param_scoreboard.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_scoreboard.sv
// Parametrised two-read/one-write register file with an asynchronous clear,
// an optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_param_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter bit ZERO_REG  = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ADDR_BITS-1:0] ReadRegister1,
    input  logic [ADDR_BITS-1:0] ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    output logic                 Pending1,
    output logic                 Pending2,
    input  logic [ADDR_BITS-1:0] WriteRegister,
    input  logic [WIDTH-1:0]     WriteData,
    input  logic                 RegWrite,
    input  logic [ADDR_BITS-1:0] IssueRegister,
    input  logic                 IssueValid,
    output logic [ADDR_BITS:0]   PendingCount
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]   pend;
    logic [DEPTH-1:0]   pend_next;
    logic [ADDR_BITS:0] count_next;
    logic               wr_en;
    logic               iss_en;

    // Qualified write/issue: writes and issues to a hardwired r0 never happen.
    always_comb begin
        wr_en  = RegWrite && !Reset && !(ZERO_REG && (WriteRegister == '0));
        iss_en = IssueValid && !Reset && !(ZERO_REG && (IssueRegister == '0));
    end

    // NOTE: every variable gets a default at the top of the block, so no path
    // through the if-chain leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_next = pend;
        if (wr_en) begin
            pend_next[WriteRegister] = 1'b0;
        end
        // Applied after the clear so a new producer supersedes the writeback.
        if (iss_en) begin
            pend_next[IssueRegister] = 1'b1;
        end
        if (ZERO_REG) begin
            pend_next[0] = 1'b0;
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + {{ADDR_BITS{1'b0}}, pend_next[i]};
        end
    end

    // NOTE: the register array is reset on purpose: the asynchronous clear is
    // architecturally visible, so every entry must read 0 without a clock.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend         <= '0;
            PendingCount <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // sampling pre-edge values, independent of statement order.
            if (wr_en) begin
                regs[WriteRegister] <= WriteData;
            end
            pend         <= pend_next;
            PendingCount <= count_next;
        end
    end

    // Read port 1: zero register, then same-cycle bypass, then stored state.
    always_comb begin
        ReadData1 = regs[ReadRegister1];
        Pending1  = pend[ReadRegister1];
        if (ZERO_REG && (ReadRegister1 == '0)) begin
            ReadData1 = '0;
            Pending1  = 1'b0;
        end else if (BYPASS && wr_en && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
            if (!(iss_en && (IssueRegister == ReadRegister1))) begin
                Pending1 = 1'b0;
            end
        end
    end

    always_comb begin
        ReadData2 = regs[ReadRegister2];
        Pending2  = pend[ReadRegister2];
        if (ZERO_REG && (ReadRegister2 == '0)) begin
            ReadData2 = '0;
            Pending2  = 1'b0;
        end else if (BYPASS && wr_en && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
            if (!(iss_en && (IssueRegister == ReadRegister2))) begin
                Pending2 = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param_scoreboard.sv
// Scoreboard bench for regfile_param_scoreboard: three parameter variants,
// directed stimulus pushes expectations, a negedge monitor pops and compares.
module tb_regfile_param_scoreboard;

    typedef enum int {
        A_RD1, A_RD2, A_P1, A_P2, A_CNT,
        B_RD1, B_RD2, B_P1, B_CNT,
        C_RD1, C_RD2, C_CNT
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Variant A: defaults (32 bits, 32 regs, zero reg, bypass).
    logic [4:0]  a_rr1 = '0, a_rr2 = '0, a_wr = '0, a_ir = '0;
    logic [31:0] a_wd = '0, a_rd1, a_rd2;
    logic        a_we = 1'b0, a_iv = 1'b0, a_p1, a_p2;
    logic [5:0]  a_cnt;

    // Variant B: no zero register, no bypass.
    logic [4:0]  b_rr1 = '0, b_rr2 = '0, b_wr = '0, b_ir = '0;
    logic [31:0] b_wd = '0, b_rd1, b_rd2;
    logic        b_we = 1'b0, b_iv = 1'b0, b_p1, b_p2;
    logic [5:0]  b_cnt;

    // Variant C: 16-bit data, 8 registers.
    logic [2:0]  c_rr1 = '0, c_rr2 = '0, c_wr = '0, c_ir = '0;
    logic [15:0] c_wd = '0, c_rd1, c_rd2;
    logic        c_we = 1'b0, c_iv = 1'b0, c_p1, c_p2;
    logic [3:0]  c_cnt;

    regfile_param_scoreboard u_a (
        .Clk(clk), .Reset(rst),
        .ReadRegister1(a_rr1), .ReadRegister2(a_rr2),
        .ReadData1(a_rd1), .ReadData2(a_rd2),
        .Pending1(a_p1), .Pending2(a_p2),
        .WriteRegister(a_wr), .WriteData(a_wd), .RegWrite(a_we),
        .IssueRegister(a_ir), .IssueValid(a_iv), .PendingCount(a_cnt)
    );

    regfile_param_scoreboard #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .Clk(clk), .Reset(rst),
        .ReadRegister1(b_rr1), .ReadRegister2(b_rr2),
        .ReadData1(b_rd1), .ReadData2(b_rd2),
        .Pending1(b_p1), .Pending2(b_p2),
        .WriteRegister(b_wr), .WriteData(b_wd), .RegWrite(b_we),
        .IssueRegister(b_ir), .IssueValid(b_iv), .PendingCount(b_cnt)
    );

    regfile_param_scoreboard #(.WIDTH(16), .ADDR_BITS(3)) u_c (
        .Clk(clk), .Reset(rst),
        .ReadRegister1(c_rr1), .ReadRegister2(c_rr2),
        .ReadData1(c_rd1), .ReadData2(c_rd2),
        .Pending1(c_p1), .Pending2(c_p2),
        .WriteRegister(c_wr), .WriteData(c_wd), .RegWrite(c_we),
        .IssueRegister(c_ir), .IssueValid(c_iv), .PendingCount(c_cnt)
    );

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            A_RD1:   return a_rd1;
            A_RD2:   return a_rd2;
            A_P1:    return {31'd0, a_p1};
            A_P2:    return {31'd0, a_p2};
            A_CNT:   return {26'd0, a_cnt};
            B_RD1:   return b_rd1;
            B_RD2:   return b_rd2;
            B_P1:    return {31'd0, b_p1};
            B_CNT:   return {26'd0, b_cnt};
            C_RD1:   return {16'd0, c_rd1};
            C_RD2:   return {16'd0, c_rd2};
            C_CNT:   return {28'd0, c_cnt};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push_exp(input sig_e s, input logic [31:0] v, input string n);
        q.push_back('{name: n, sel: s, exp: v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, so every queued expectation is
    // compared at the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = q.pop_front();
            act = sample(e.sel);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        step();
        step();
        rst = 1'b0;

        // Reset state.
        a_rr1 = 5'd5;
        push_exp(A_RD1, 32'h0, "reset_rd1");
        push_exp(A_CNT, 32'h0, "reset_cnt");
        push_exp(C_CNT, 32'h0, "reset_c_cnt");

        // Write r5 and issue it in the same cycle, then clear asynchronously.
        step();
        a_we = 1'b1; a_wr = 5'd5; a_wd = 32'hDEAD_BEEF;
        a_iv = 1'b1; a_ir = 5'd5;
        step();
        a_we = 1'b0; a_iv = 1'b0;
        push_exp(A_RD1, 32'hDEAD_BEEF, "r5_written");
        push_exp(A_P1,  32'h1,         "r5_pending");
        push_exp(A_CNT, 32'h1,         "r5_cnt");
        step();
        #1 rst = 1'b1;
        push_exp(A_RD1, 32'h0, "async_clear_rd1");
        push_exp(A_P1,  32'h0, "async_clear_p1");
        push_exp(A_CNT, 32'h0, "async_clear_cnt");
        step();
        rst = 1'b0;

        // Zero register on A (hardwired) and B (ordinary register).
        a_we = 1'b1; a_wr = 5'd0; a_wd = 32'hFFFF_FFFF; a_rr1 = 5'd0;
        b_we = 1'b1; b_wr = 5'd0; b_wd = 32'hFFFF_FFFF; b_rr1 = 5'd0;
        push_exp(A_RD1, 32'h0, "zero_write_bypass");
        push_exp(B_RD1, 32'h0, "nobypass_r0_old");
        step();
        a_we = 1'b0; a_iv = 1'b1; a_ir = 5'd0;
        b_we = 1'b0; b_iv = 1'b1; b_ir = 5'd0;
        push_exp(A_RD1, 32'h0,         "zero_after_write");
        push_exp(B_RD1, 32'hFFFF_FFFF, "r0_nonzero_reg");
        step();
        a_iv = 1'b0; b_iv = 1'b0;
        push_exp(A_P1,  32'h0, "zero_issue_p1");
        push_exp(A_CNT, 32'h0, "zero_issue_cnt");
        push_exp(B_P1,  32'h1, "r0_issue_p1_b");
        push_exp(B_CNT, 32'h1, "r0_issue_cnt_b");

        // Bypass versus no bypass on r7.
        step();
        a_we = 1'b1; a_wr = 5'd7; a_wd = 32'h1234_5678; a_rr2 = 5'd7;
        b_we = 1'b1; b_wr = 5'd7; b_wd = 32'h1234_5678; b_rr2 = 5'd7;
        push_exp(A_RD2, 32'h1234_5678, "bypass_same_cycle");
        push_exp(B_RD2, 32'h0,         "nobypass_old_value");
        step();
        a_we = 1'b0; b_we = 1'b0;
        push_exp(A_RD2, 32'h1234_5678, "bypass_stored");
        push_exp(B_RD2, 32'h1234_5678, "nobypass_next_cycle");
        push_exp(A_CNT, 32'h0,         "write_nonpending_cnt");

        // Scoreboard lifecycle: issue r3, r4, then write back r3.
        step();
        a_iv = 1'b1; a_ir = 5'd3;
        step();
        a_ir = 5'd4;
        step();
        a_iv = 1'b0; a_rr1 = 5'd3; a_rr2 = 5'd4;
        push_exp(A_CNT, 32'h2, "issue2_cnt");
        push_exp(A_P1,  32'h1, "issue_r3_p1");
        push_exp(A_P2,  32'h1, "issue_r4_p2");
        step();
        a_we = 1'b1; a_wr = 5'd3; a_wd = 32'h0000_0033;
        push_exp(A_P1,  32'h0,  "wb_bypass_p1");
        push_exp(A_P2,  32'h1,  "wb_other_p2");
        push_exp(A_CNT, 32'h2,  "wb_cnt_before_edge");
        push_exp(A_RD1, 32'h33, "wb_bypass_rd1");
        step();
        a_we = 1'b0;
        push_exp(A_CNT, 32'h1, "wb_cnt_after_edge");
        push_exp(A_P1,  32'h0, "wb_p1_after_edge");

        // Re-issue of an already pending register leaves the count alone.
        a_iv = 1'b1; a_ir = 5'd4;
        step();
        a_ir = 5'd9;
        push_exp(A_CNT, 32'h1, "reissue_cnt");
        step();

        // Issue and write r9 in the same cycle while r9 is pending.
        a_iv = 1'b1; a_ir = 5'd9;
        a_we = 1'b1; a_wr = 5'd9; a_wd = 32'hA5A5_A5A5; a_rr1 = 5'd9;
        push_exp(A_P1,  32'h1,         "simul_p1_same_cycle");
        push_exp(A_CNT, 32'h2,         "simul_cnt_before");
        push_exp(A_RD1, 32'hA5A5_A5A5, "simul_bypass_rd1");
        step();
        a_iv = 1'b0; a_we = 1'b0; a_rr2 = 5'd9;
        push_exp(A_P1,  32'h1,         "simul_p9_kept");
        push_exp(A_CNT, 32'h2,         "simul_cnt_after");
        push_exp(A_RD1, 32'hA5A5_A5A5, "simul_data_stored");
        push_exp(A_RD2, 32'hA5A5_A5A5, "same_addr_rd2");
        push_exp(A_P2,  32'h1,         "same_addr_p2");

        // Small variant: write every register, read both ports, issue all.
        for (int i = 0; i < 8; i++) begin
            step();
            c_we = 1'b1; c_wr = 3'(i); c_wd = 16'(i * 16'h1111);
        end
        step();
        c_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_rr1 = 3'(i);
            c_rr2 = 3'(7 - i);
            push_exp(C_RD1, (i == 0) ? 32'h0 : 32'(i * 16'h1111), "sweep_rd1");
            push_exp(C_RD2, (i == 7) ? 32'h0 : 32'((7 - i) * 16'h1111), "sweep_rd2");
            step();
        end
        for (int i = 0; i < 8; i++) begin
            c_iv = 1'b1; c_ir = 3'(i);
            step();
        end
        c_iv = 1'b0;
        push_exp(C_CNT, 32'h7, "sweep_full_cnt");

        step();
        step();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL monitor_drain: got %0d unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
